// File: rtl/datapath_ctrl.sv
// ----------------------------------------------------------------------------
// datapath_ctrl
//   Multi-cycle control FSM for a 16-bit, 8-register load/store datapath.
//   Each instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and
//   returns to FETCH. A JALR with a non-zero immediate parks the block in
//   HALT until reset.
//
// Ports
//   clk       in   clock; all state changes on its rising edge
//   rst       in   synchronous, active-high reset
//   instr     in   instruction-register contents, opcode in instr[15:13]
//   mem_ack   in   memory completion for the outstanding mem_req
//   alu_eq    in   datapath equality flag (outa == outb)
//   mux_rt    out  1: src2 address from instr[2:0], 0: from instr[12:10]
//   mux_outa  out  1: register src1, 0: left-shifted immediate
//   mux_outb  out  1: register src2, 0: sign-extended imm7
//   alu_op    out  00 add, 01 nand, 10 pass-a, 11 compare
//   ir_we     out  instruction-register write strobe
//   reg_we    out  register-file write strobe (never writes r0)
//   pc_we     out  program-counter write strobe
//   mem_req   out  memory request
//   mem_we    out  memory write (valid with mem_req)
//   pc_sel    out  00 pc+1, 01 pc+1+simm7, 10 src1 register value
//   wb_sel    out  00 ALU result, 01 memory read data, 10 pc+1
//   halted    out  high while in HALT
//
//   Outputs are decoded combinationally from the state register, instr and
//   the two handshake inputs. mem_ack and alu_eq have to steer ir_we/pc_we
//   in the same cycle to meet the zero-wait latencies (ALU 4, LW 5, SW 4,
//   BEQ 3, JALR 3 cycles).
// ----------------------------------------------------------------------------
module datapath_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        mem_ack,
    input  logic        alu_eq,
    output logic        mux_rt,
    output logic        mux_outa,
    output logic        mux_outb,
    output logic [1:0]  alu_op,
    output logic        ir_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic        halted
);

    localparam int unsigned OP_W  = 3;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned REG_W = 3;
    localparam int unsigned IMM_W = 7;

    // Opcode map (instr[15:13])
    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_ADDI = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND = 3'd2;
    localparam logic [OP_W-1:0] OP_LUI  = 3'd3;
    localparam logic [OP_W-1:0] OP_SW   = 3'd4;
    localparam logic [OP_W-1:0] OP_LW   = 3'd5;
    localparam logic [OP_W-1:0] OP_BEQ  = 3'd6;
    localparam logic [OP_W-1:0] OP_JALR = 3'd7;

    localparam logic [SEL_W-1:0] ALU_ADD  = 2'b00;
    localparam logic [SEL_W-1:0] ALU_NAND = 2'b01;
    localparam logic [SEL_W-1:0] ALU_PASS = 2'b10;
    localparam logic [SEL_W-1:0] ALU_CMP  = 2'b11;

    localparam logic [SEL_W-1:0] PC_INC    = 2'b00;
    localparam logic [SEL_W-1:0] PC_BRANCH = 2'b01;
    localparam logic [SEL_W-1:0] PC_REG    = 2'b10;

    localparam logic [SEL_W-1:0] WB_ALU = 2'b00;
    localparam logic [SEL_W-1:0] WB_MEM = 2'b01;
    localparam logic [SEL_W-1:0] WB_PC1 = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    state_e state_q;
    state_e state_d;

    // Instruction fields
    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] reg_a;
    logic [IMM_W-1:0] imm7;
    logic             is_sw;
    logic             is_lw;
    logic             dest_is_r0;
    logic             jalr_halt;
    logic             unused_instr_bits;

    assign opcode     = instr[15:13];
    assign reg_a      = instr[12:10];
    assign imm7       = instr[6:0];
    assign is_sw      = (opcode == OP_SW);
    assign is_lw      = (opcode == OP_LW);
    assign dest_is_r0 = (reg_a == REG_W'(0));
    // JALR with a non-zero immediate is the halt encoding
    assign jalr_halt  = (imm7 != IMM_W'(0));
    // regB is routed by the datapath muxes, not inspected here
    assign unused_instr_bits = ^instr[9:7];

    // Per-opcode operand routing, held from DECODE through WB
    logic             dec_rt;
    logic             dec_outa;
    logic             dec_outb;
    logic [SEL_W-1:0] dec_alu_op;

    always_comb begin
        dec_rt     = 1'b0;
        dec_outa   = 1'b1;
        dec_outb   = 1'b0;
        dec_alu_op = ALU_ADD;
        case (opcode)
            OP_ADD: begin
                dec_rt   = 1'b1;
                dec_outb = 1'b1;
            end
            OP_NAND: begin
                dec_rt     = 1'b1;
                dec_outb   = 1'b1;
                dec_alu_op = ALU_NAND;
            end
            OP_ADDI, OP_LW, OP_SW: begin
                // src2 address from regA doubles as store-data source for SW
                dec_rt   = 1'b0;
                dec_outb = 1'b0;
            end
            OP_LUI: begin
                // don't-care selects parked at 0
                dec_outa   = 1'b0;
                dec_alu_op = ALU_PASS;
            end
            OP_BEQ: begin
                dec_outb   = 1'b1;
                dec_alu_op = ALU_CMP;
            end
            OP_JALR: begin
                dec_outb = 1'b0;
            end
            default: begin
                dec_rt = 1'b0;
            end
        endcase
    end

    // State register; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ack) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ:       state_d = S_FETCH;
                    OP_JALR:      state_d = jalr_halt ? S_HALT : S_FETCH;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output decode; everything idles at 0 while rst is high
    logic reg_we_raw;

    always_comb begin
        mux_rt     = 1'b0;
        mux_outa   = 1'b0;
        mux_outb   = 1'b0;
        alu_op     = ALU_ADD;
        ir_we      = 1'b0;
        reg_we_raw = 1'b0;
        pc_we      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        pc_sel     = PC_INC;
        wb_sel     = WB_ALU;
        halted     = 1'b0;

        if (!rst) begin
            if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
                mux_rt   = dec_rt;
                mux_outa = dec_outa;
                mux_outb = dec_outb;
                alu_op   = dec_alu_op;
            end

            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ack;
                end
                S_EXEC: begin
                    if (opcode == OP_BEQ) begin
                        pc_we  = 1'b1;
                        pc_sel = alu_eq ? PC_BRANCH : PC_INC;
                    end else if ((opcode == OP_JALR) && !jalr_halt) begin
                        // link and jump in one cycle
                        reg_we_raw = 1'b1;
                        wb_sel     = WB_PC1;
                        pc_we      = 1'b1;
                        pc_sel     = PC_REG;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = is_sw;
                    // SW retires on the ack; LW still needs its WB cycle
                    pc_we   = mem_ack && is_sw;
                end
                S_WB: begin
                    reg_we_raw = 1'b1;
                    pc_we      = 1'b1;
                    wb_sel     = is_lw ? WB_MEM : WB_ALU;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

    // r0 is hard-wired: suppress any write addressed to it
    assign reg_we = reg_we_raw && !dest_is_r0;

endmodule

// File: tb/tb_datapath_ctrl.sv
// ----------------------------------------------------------------------------
// tb_datapath_ctrl
//   Cycle-accurate bench for datapath_ctrl. Each scenario task lists the
//   expected output vector for every cycle; the vector is pushed onto the
//   scoreboard queue as that cycle's inputs are driven and popped when the
//   outputs are sampled on the falling edge.
//   Output vector layout (15 bits):
//     {mux_rt, mux_outa, mux_outb, alu_op[1:0],
//      ir_we, reg_we, pc_we, mem_req, mem_we, pc_sel[1:0], wb_sel[1:0], halted}
// ----------------------------------------------------------------------------
module tb_datapath_ctrl;

    typedef logic [14:0] ov_t;

    logic        clk = 1'b1;
    logic        rst;
    logic [15:0] instr;
    logic        mem_ack;
    logic        alu_eq;
    logic        mux_rt;
    logic        mux_outa;
    logic        mux_outb;
    logic [1:0]  alu_op;
    logic        ir_we;
    logic        reg_we;
    logic        pc_we;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  pc_sel;
    logic [1:0]  wb_sel;
    logic        halted;

    int  checks = 0;
    int  errors = 0;
    ov_t exp_q[$];

    datapath_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .mem_ack  (mem_ack),
        .alu_eq   (alu_eq),
        .mux_rt   (mux_rt),
        .mux_outa (mux_outa),
        .mux_outb (mux_outb),
        .alu_op   (alu_op),
        .ir_we    (ir_we),
        .reg_we   (reg_we),
        .pc_we    (pc_we),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .pc_sel   (pc_sel),
        .wb_sel   (wb_sel),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // Strobe groups {ir_we, reg_we, pc_we, mem_req, mem_we}
    localparam logic [4:0] S_NONE  = 5'b00000;
    localparam logic [4:0] S_REQ   = 5'b00010;
    localparam logic [4:0] S_IRREQ = 5'b10010;
    localparam logic [4:0] S_REGPC = 5'b01100;
    localparam logic [4:0] S_PC    = 5'b00100;
    localparam logic [4:0] S_STORE = 5'b00111;

    function automatic ov_t mk(input logic [2:0] mx, input logic [1:0] aop,
                               input logic [4:0] stb, input logic [1:0] psel,
                               input logic [1:0] wsel, input logic hlt);
        return {mx, aop, stb, psel, wsel, hlt};
    endfunction

    function automatic ov_t obs();
        return {mux_rt, mux_outa, mux_outb, alu_op, ir_we, reg_we, pc_we,
                mem_req, mem_we, pc_sel, wb_sel, halted};
    endfunction

    localparam ov_t ZERO   = 15'b000_00_00000_00_00_0;
    localparam ov_t F_IDLE = 15'b000_00_00010_00_00_0;
    localparam ov_t F_ACK  = 15'b000_00_10010_00_00_0;

    task automatic test_reset();
        ov_t ev[$] = '{ZERO, ZERO, F_IDLE, F_IDLE};
        logic [31:0] rst_v = 32'b0011;
        logic [31:0] ack_v = 32'b0010;
        ov_t got, want;
        int c = 0;
        instr  = 16'h0000;
        alu_eq = 1'b0;
        while (ev.size() != 0) begin
            rst = rst_v[0]; mem_ack = ack_v[0];
            rst_v = rst_v >> 1; ack_v = ack_v >> 1;
            exp_q.push_back(ev.pop_front());
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset c%0d got=%h want=%h", c, got, want);
            end
            @(posedge clk); #1; c++;
        end
    endtask

    // ADD r1,r2,r3 with zero-wait fetch; stray acks in DECODE/EXEC/WB ignored
    task automatic test_add();
        ov_t dx = mk(3'b111, 2'b00, S_NONE, 2'b00, 2'b00, 1'b0);
        ov_t wb = mk(3'b111, 2'b00, S_REGPC, 2'b00, 2'b00, 1'b0);
        ov_t ev[$] = '{F_ACK, dx, dx, wb, F_IDLE};
        logic [31:0] ack_v = 32'b01111;
        ov_t got, want;
        int c = 0;
        instr = 16'h0503; rst = 1'b0; alu_eq = 1'b0;
        while (ev.size() != 0) begin
            mem_ack = ack_v[0]; ack_v = ack_v >> 1;
            exp_q.push_back(ev.pop_front());
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL add c%0d got=%h want=%h", c, got, want);
            end
            @(posedge clk); #1; c++;
        end
    endtask

    // NAND r3,r1,r2 followed by LUI r4
    task automatic test_nand_lui();
        ov_t nd = mk(3'b111, 2'b01, S_NONE, 2'b00, 2'b00, 1'b0);
        ov_t nw = mk(3'b111, 2'b01, S_REGPC, 2'b00, 2'b00, 1'b0);
        ov_t ld = mk(3'b000, 2'b10, S_NONE, 2'b00, 2'b00, 1'b0);
        ov_t lw = mk(3'b000, 2'b10, S_REGPC, 2'b00, 2'b00, 1'b0);
        ov_t ev[$] = '{F_ACK, nd, nd, nw, F_ACK, ld, ld, lw, F_IDLE};
        logic [31:0] ack_v = 32'b000010001;
        ov_t got, want;
        int c = 0;
        rst = 1'b0; alu_eq = 1'b1;
        while (ev.size() != 0) begin
            instr = (c < 4) ? 16'h4C82 : 16'h7005;
            mem_ack = ack_v[0]; ack_v = ack_v >> 1;
            exp_q.push_back(ev.pop_front());
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL nand_lui c%0d got=%h want=%h", c, got, want);
            end
            @(posedge clk); #1; c++;
        end
    endtask

    // LW r2,r1,5: one fetch wait state, then three MEM cycles before the ack
    task automatic test_lw();
        ov_t lx = mk(3'b010, 2'b00, S_NONE, 2'b00, 2'b00, 1'b0);
        ov_t lm = mk(3'b010, 2'b00, S_REQ, 2'b00, 2'b00, 1'b0);
        ov_t lw = mk(3'b010, 2'b00, S_REGPC, 2'b00, 2'b01, 1'b0);
        ov_t ev[$] = '{F_IDLE, F_ACK, lx, lx, lm, lm, lm, lw, F_IDLE};
        logic [31:0] ack_v = 32'b001000010;
        ov_t got, want;
        int c = 0;
        instr = 16'hA885; rst = 1'b0; alu_eq = 1'b0;
        while (ev.size() != 0) begin
            mem_ack = ack_v[0]; ack_v = ack_v >> 1;
            exp_q.push_back(ev.pop_front());
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL lw c%0d got=%h want=%h", c, got, want);
            end
            @(posedge clk); #1; c++;
        end
    endtask

    // SW r1,r2,0 with zero-wait memory: retires in MEM, 4 cycles total
    task automatic test_sw();
        ov_t sx = mk(3'b010, 2'b00, S_NONE, 2'b00, 2'b00, 1'b0);
        ov_t sm = mk(3'b010, 2'b00, S_STORE, 2'b00, 2'b00, 1'b0);
        ov_t ev[$] = '{F_ACK, sx, sx, sm, F_IDLE};
        logic [31:0] ack_v = 32'b01001;
        ov_t got, want;
        int c = 0;
        instr = 16'h8500; rst = 1'b0; alu_eq = 1'b0;
        while (ev.size() != 0) begin
            mem_ack = ack_v[0]; ack_v = ack_v >> 1;
            exp_q.push_back(ev.pop_front());
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sw c%0d got=%h want=%h", c, got, want);
            end
            @(posedge clk); #1; c++;
        end
    endtask

    // BEQ taken then not taken
    task automatic test_beq();
        ov_t bd = mk(3'b011, 2'b11, S_NONE, 2'b00, 2'b00, 1'b0);
        ov_t bt = mk(3'b011, 2'b11, S_PC, 2'b01, 2'b00, 1'b0);
        ov_t bn = mk(3'b011, 2'b11, S_PC, 2'b00, 2'b00, 1'b0);
        ov_t ev[$] = '{F_ACK, bd, bt, F_ACK, bd, bn, F_IDLE};
        logic [31:0] ack_v = 32'b0001001;
        logic [31:0] eq_v  = 32'b0000111;
        ov_t got, want;
        int c = 0;
        instr = 16'hC07F; rst = 1'b0;
        while (ev.size() != 0) begin
            mem_ack = ack_v[0]; alu_eq = eq_v[0];
            ack_v = ack_v >> 1; eq_v = eq_v >> 1;
            exp_q.push_back(ev.pop_front());
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL beq c%0d got=%h want=%h", c, got, want);
            end
            @(posedge clk); #1; c++;
        end
    endtask

    // JALR r1,r2 links and jumps; JALR r0,r1 jumps without writing r0
    task automatic test_jalr_link();
        ov_t jd = mk(3'b010, 2'b00, S_NONE, 2'b00, 2'b00, 1'b0);
        ov_t jl = mk(3'b010, 2'b00, S_REGPC, 2'b10, 2'b10, 1'b0);
        ov_t j0 = mk(3'b010, 2'b00, S_PC, 2'b10, 2'b10, 1'b0);
        ov_t ev[$] = '{F_ACK, jd, jl, F_ACK, jd, j0, F_IDLE};
        logic [31:0] ack_v = 32'b0001001;
        ov_t got, want;
        int c = 0;
        rst = 1'b0; alu_eq = 1'b0;
        while (ev.size() != 0) begin
            instr = (c < 3) ? 16'hE500 : 16'hE080;
            mem_ack = ack_v[0]; ack_v = ack_v >> 1;
            exp_q.push_back(ev.pop_front());
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL jalr c%0d got=%h want=%h", c, got, want);
            end
            @(posedge clk); #1; c++;
        end
    endtask

    // ADDI r0,r0,1: write to r0 suppressed, pc still advances
    task automatic test_addi_r0();
        ov_t ad = mk(3'b010, 2'b00, S_NONE, 2'b00, 2'b00, 1'b0);
        ov_t aw = mk(3'b010, 2'b00, S_PC, 2'b00, 2'b00, 1'b0);
        ov_t ev[$] = '{F_ACK, ad, ad, aw, F_IDLE};
        logic [31:0] ack_v = 32'b00001;
        ov_t got, want;
        int c = 0;
        instr = 16'h2001; rst = 1'b0; alu_eq = 1'b0;
        while (ev.size() != 0) begin
            mem_ack = ack_v[0]; ack_v = ack_v >> 1;
            exp_q.push_back(ev.pop_front());
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL addi_r0 c%0d got=%h want=%h", c, got, want);
            end
            @(posedge clk); #1; c++;
        end
    endtask

    // Reset in MEM with mem_ack in the same cycle: back to FETCH, no WB
    task automatic test_rst_in_mem();
        ov_t lx = mk(3'b010, 2'b00, S_NONE, 2'b00, 2'b00, 1'b0);
        ov_t lm = mk(3'b010, 2'b00, S_REQ, 2'b00, 2'b00, 1'b0);
        ov_t ev[$] = '{F_ACK, lx, lx, lm, ZERO, F_IDLE, F_IDLE};
        logic [31:0] rst_v = 32'b0010000;
        logic [31:0] ack_v = 32'b0010001;
        ov_t got, want;
        int c = 0;
        instr = 16'hA885; alu_eq = 1'b0;
        while (ev.size() != 0) begin
            rst = rst_v[0]; mem_ack = ack_v[0];
            rst_v = rst_v >> 1; ack_v = ack_v >> 1;
            exp_q.push_back(ev.pop_front());
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rst_in_mem c%0d got=%h want=%h", c, got, want);
            end
            @(posedge clk); #1; c++;
        end
    endtask

    // JALR halt: 20 HALT cycles with toggling mem_ack, then reset out
    task automatic test_halt();
        ov_t hd = mk(3'b010, 2'b00, S_NONE, 2'b00, 2'b00, 1'b0);
        ov_t hh = mk(3'b000, 2'b00, S_NONE, 2'b00, 2'b00, 1'b1);
        ov_t ev[$];
        ov_t got, want;
        int c = 0;
        for (int i = 0; i < 25; i++) begin
            ev.push_back((i == 0) ? F_ACK : (i < 3) ? hd : (i < 23) ? hh :
                         (i == 23) ? ZERO : F_IDLE);
        end
        instr = 16'hE001;
        while (ev.size() != 0) begin
            rst     = (c == 23);
            mem_ack = (c == 0) || ((c >= 3) && (c < 23) && ((c % 2) == 1));
            alu_eq  = ((c % 3) == 0);
            exp_q.push_back(ev.pop_front());
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL halt c%0d got=%h want=%h", c, got, want);
            end
            @(posedge clk); #1; c++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_nand_lui();
        test_lw();
        test_sw();
        test_beq();
        test_jalr_link();
        test_addi_r0();
        test_rst_in_mem();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
